// File: rtl/stream_scheduler.sv
// rtl/stream_scheduler.sv - FIFO-to-sink sample scheduler feeding a UART or I2S sink
// Underrun statistics are compiled in only when STREAM_SCHED_STATS_EN is defined.
module stream_scheduler #(
  parameter int BPS         = 24,
  parameter int LEVEL_W     = 10,
  parameter int PREFILL_LVL = 256,
  parameter int PACE_DIV    = 36864000
) (
  input  logic               in_clk,
  input  logic               in_reset,
  input  logic [BPS-1:0]     in_sample,
  input  logic               in_fifo_empty,
  input  logic [LEVEL_W-1:0] in_fifo_level,
  output logic               out_fifo_rd_en,
  input  logic [1:0]         in_mode,
  output logic [BPS-1:0]     out_uart_sample,
  output logic               out_uart_valid,
  input  logic               in_uart_ready,
  output logic [BPS-1:0]     out_i2s_sample,
  output logic               out_i2s_valid,
  input  logic               in_i2s_ready,
  output logic               out_active,
  output logic [15:0]        out_underrun_cnt
);
  localparam logic [1:0] MODE_UART     = 2'b00;
  localparam logic [1:0] MODE_I2S_SLOW = 2'b01;
  localparam logic [1:0] MODE_HOLD     = 2'b11;
  localparam int PACE_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
  localparam logic [PACE_W-1:0]  PACE_LAST  = PACE_W'(PACE_DIV - 1);
  localparam logic [LEVEL_W-1:0] PREFILL_TH = LEVEL_W'(PREFILL_LVL);

  typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_REQ, S_FETCH, S_PRESENT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [BPS-1:0]     sample_q, sample_d;
  logic [PACE_W-1:0]  pace_cnt_q, pace_cnt_d;
  logic               pending_q, pending_d;
  logic               rd_req, mode_changed, i2s_mode, pace_ok, sink_ready, enter_prefill;
  logic [LEVEL_W-1:0] fill_th;

  assign mode_changed = (in_mode != mode_q);
  assign i2s_mode     = (mode_q != MODE_UART);
  assign pace_ok      = (mode_q != MODE_I2S_SLOW) || pending_q;
  assign sink_ready   = i2s_mode ? in_i2s_ready : in_uart_ready;
  assign fill_th      = i2s_mode ? PREFILL_TH : LEVEL_W'(1);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sample_d = sample_q;
    rd_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_mode != MODE_HOLD) begin
          mode_d  = in_mode;
          state_d = S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (mode_changed)                 state_d = S_IDLE;
        else if (in_fifo_level >= fill_th) state_d = S_REQ;
      end
      S_REQ: begin
        if (mode_changed) begin
          state_d = S_IDLE;
        end else if (pace_ok) begin
          if (in_fifo_empty) begin
            state_d = S_PREFILL;
          end else begin
            rd_req  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        sample_d = in_sample;
        state_d  = S_PRESENT;
      end
      S_PRESENT: begin
        // A pending mode change waits until the in-flight sample is accepted.
        if (sink_ready) state_d = mode_changed ? S_IDLE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_prefill = (state_d == S_PREFILL) && (state_q != S_PREFILL);

  always_comb begin
    pace_cnt_d = pace_cnt_q;
    pending_d  = pending_q;
    if (state_q == S_IDLE || mode_q != MODE_I2S_SLOW || enter_prefill) begin
      pace_cnt_d = '0;
      pending_d  = 1'b0;
    end else if (pace_cnt_q == PACE_LAST) begin
      pace_cnt_d = '0;
      pending_d  = 1'b1;
    end else begin
      pace_cnt_d = pace_cnt_q + PACE_W'(1);
      if (rd_req) pending_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_UART;
      sample_q   <= '0;
      pace_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sample_q   <= sample_d;
      pace_cnt_q <= pace_cnt_d;
      pending_q  <= pending_d;
    end
  end

`ifdef STREAM_SCHED_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic        underrun_evt;

  assign underrun_evt = (state_q == S_REQ) && !mode_changed && pace_ok && in_fifo_empty && i2s_mode;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_evt && underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) underrun_cnt_q <= '0;
    else          underrun_cnt_q <= underrun_cnt_d;
  end

  assign out_underrun_cnt = underrun_cnt_q;
`else
  assign out_underrun_cnt = 16'd0;
`endif

  // Reset gates the handshake outputs immediately, even mid-transfer.
  assign out_fifo_rd_en  = rd_req && !in_reset;
  assign out_uart_valid  = (state_q == S_PRESENT) && !i2s_mode && !in_reset;
  assign out_i2s_valid   = (state_q == S_PRESENT) && i2s_mode && !in_reset;
  assign out_uart_sample = sample_q;
  assign out_i2s_sample  = sample_q;
  assign out_active      = (state_q != S_IDLE) && !in_reset;

endmodule

// File: tb/tb_stream_scheduler.sv
// tb/tb_stream_scheduler.sv - randomized and directed checks of stream_scheduler against a transaction-level model
module tb_stream_scheduler;
  localparam int BPS = 24, LEVEL_W = 10, PREFILL_LVL = 256, PACE_DIV = 100;
`ifdef STREAM_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [BPS-1:0]      sample_in = '0;
  logic                fifo_empty = 1'b1;
  logic [LEVEL_W-1:0]  fifo_level = '0;
  logic                rd_en;
  logic [1:0]          mode = 2'b11;
  logic [BPS-1:0]      uart_sample, i2s_sample;
  logic                uart_valid, i2s_valid, active;
  logic                uart_ready = 1'b1, i2s_ready = 1'b1;
  logic [15:0]         underrun_cnt;

  stream_scheduler #(.BPS(BPS), .LEVEL_W(LEVEL_W), .PREFILL_LVL(PREFILL_LVL), .PACE_DIV(PACE_DIV)) dut (
    .in_clk(clk), .in_reset(rst), .in_sample(sample_in), .in_fifo_empty(fifo_empty),
    .in_fifo_level(fifo_level), .out_fifo_rd_en(rd_en), .in_mode(mode),
    .out_uart_sample(uart_sample), .out_uart_valid(uart_valid), .in_uart_ready(uart_ready),
    .out_i2s_sample(i2s_sample), .out_i2s_valid(i2s_valid), .in_i2s_ready(i2s_ready),
    .out_active(active), .out_underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  longint cyc = 0;

  logic s_reset = 1'b1, s_ur = 1'b1, s_ir = 1'b1, s_push = 1'b0;
  logic [1:0] s_mode = 2'b11;
  logic [BPS-1:0] s_push_val = '0;

  logic [BPS-1:0] fifo_q[$];
  logic [BPS-1:0] fifo_dout = '0;

  // Model: where the current transfer stands, plus pacing kept as cycle arithmetic.
  bit m_active, m_filling, m_fetching, m_presenting;
  int m_mode = 3;
  logic [BPS-1:0] m_sample = '0;
  int m_under = 0;
  longint m_zero = 0, m_last_consume = 0;

  longint rd_log[$], uv_log[$], iv_log[$];
  logic [BPS-1:0] uv_smp[$];

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pace_ok();
    longint n;
    if (m_mode != 1) return 1'b1;
    if (cyc < m_zero + PACE_DIV) return 1'b0;
    n = (cyc - m_zero) / PACE_DIV;
    return (m_zero + n * PACE_DIV) > m_last_consume;
  endfunction

  task automatic enter_fill();
    m_filling = 1;
    m_zero = cyc + 1;
    m_last_consume = cyc;
  endtask

  task automatic cycle();
    bit rd_e, uv_e, iv_e, act_e, empty, changed, pok, sel_ready;
    int lvl;
    @(negedge clk);
    rst = s_reset; mode = s_mode; uart_ready = s_ur; i2s_ready = s_ir;
    lvl = fifo_q.size();
    empty = (lvl == 0);
    fifo_empty = empty; fifo_level = lvl[LEVEL_W-1:0]; sample_in = fifo_dout;
    #1;
    changed = (int'(s_mode) != m_mode);
    pok = pace_ok();
    rd_e  = !s_reset && m_active && !m_filling && !m_fetching && !m_presenting && !changed && pok && !empty;
    uv_e  = !s_reset && m_presenting && m_mode == 0;
    iv_e  = !s_reset && m_presenting && m_mode != 0;
    act_e = !s_reset && m_active;
    check("rd_en", rd_en, rd_e);
    check("uart_valid", uart_valid, uv_e);
    check("i2s_valid", i2s_valid, iv_e);
    check("active", active, act_e);
    check("uart_sample", uart_sample, m_sample);
    check("i2s_sample", i2s_sample, m_sample);
    check("underrun_cnt", underrun_cnt, STATS ? m_under : 0);
    if (rd_en) rd_log.push_back(cyc);
    if (uart_valid) begin uv_log.push_back(cyc); uv_smp.push_back(uart_sample); end
    if (i2s_valid) iv_log.push_back(cyc);

    if (s_reset) begin
      m_active = 0; m_filling = 0; m_fetching = 0; m_presenting = 0;
      m_sample = '0; m_under = 0;
    end else if (!m_active) begin
      if (s_mode != 2'b11) begin
        m_active = 1; m_mode = int'(s_mode); enter_fill();
      end
    end else if (m_filling) begin
      if (changed) begin m_active = 0; m_filling = 0; end
      else if (lvl >= (m_mode == 0 ? 1 : PREFILL_LVL)) m_filling = 0;
    end else if (m_fetching) begin
      m_sample = fifo_dout; m_fetching = 0; m_presenting = 1;
    end else if (m_presenting) begin
      sel_ready = (m_mode == 0) ? s_ur : s_ir;
      if (sel_ready) begin
        m_presenting = 0;
        if (changed) m_active = 0;
      end
    end else begin
      if (changed) m_active = 0;
      else if (pok) begin
        if (empty) begin
          enter_fill();
          if (m_mode != 0 && m_under < 65535) m_under++;
        end else begin
          m_fetching = 1; m_last_consume = cyc;
        end
      end
    end

    if (rd_e) fifo_dout = fifo_q.pop_front();
    if (s_push && fifo_q.size() < 1000) fifo_q.push_back(s_push_val);
    cyc++;
  endtask

  task automatic do_reset();
    s_reset = 1; s_mode = 2'b11; s_push = 0;
    cycle();
    s_reset = 0;
    cycle();
    fifo_q.delete();
    rd_log.delete(); uv_log.delete(); iv_log.delete(); uv_smp.delete();
  endtask

  initial begin
    longint start, first_rd, lvl256_cyc;
    int early_rd, held, hs, bp_rd, push_pct, lvl_now;
    logic [BPS-1:0] sample0;

    do_reset();
    check("reset_active", active, 0);
    check("reset_underrun", underrun_cnt, 0);
    check("reset_sample", uart_sample, 0);

    // UART round trip
    do_reset();
    fifo_q.push_back(24'h000001); fifo_q.push_back(24'h000002); fifo_q.push_back(24'h000003);
    s_mode = 2'b00; s_ur = 1; s_ir = 1;
    repeat (20) cycle();
    check("uart_count", uv_log.size(), 3);
    for (int i = 0; i < 3 && i < uv_log.size() && i < rd_log.size(); i++) begin
      check("uart_latency", uv_log[i] - rd_log[i], 2);
      check("uart_data", uv_smp[i], i + 1);
    end
    check("uart_i2s_quiet", iv_log.size(), 0);

    // Prefill threshold, backpressure, then drain into an underrun
    do_reset();
    s_mode = 2'b10; s_ir = 1;
    start = cyc; first_rd = -1; lvl256_cyc = -1; early_rd = 0;
    for (int k = 0; k < 400 && first_rd < 0; k++) begin
      lvl_now = fifo_q.size();
      if (lvl_now == 256 && lvl256_cyc < 0) lvl256_cyc = cyc;
      s_push = (lvl_now < 256);
      s_push_val = 24'h100 + lvl_now;
      cycle();
      if (rd_en && lvl_now <= 255) early_rd++;
      if (rd_en) first_rd = cyc - 1;
    end
    s_push = 0;
    check("prefill_early_rd", early_rd, 0);
    check("prefill_first_rd", first_rd - lvl256_cyc, 1);
    check("prefill_abs_cycle", first_rd - start, 257);

    s_ir = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (i2s_valid) break;
    end
    sample0 = i2s_sample;
    held = i2s_valid ? 1 : 0;
    hs = 0; bp_rd = 0;
    repeat (49) begin
      cycle();
      if (i2s_valid && i2s_sample == sample0) held++;
      if (rd_en) bp_rd++;
    end
    s_ir = 1;
    cycle();
    if (i2s_valid) hs++;
    if (rd_en) bp_rd++;
    cycle();
    check("bp_drop", i2s_valid, 0);
    check("bp_held", held, 50);
    check("bp_sample", sample0, 24'h100);
    check("bp_handshakes", hs, 1);
    check("bp_extra_rd", bp_rd, 0);

    for (int k = 0; k < 2000 && fifo_q.size() > 0; k++) cycle();
    repeat (10) cycle();
    check("underrun_reads", rd_log.size(), 256);
    check("underrun_cnt_lit", underrun_cnt, STATS);
    check("underrun_prefill_active", active, 1);

    // Mode-01 pacing
    do_reset();
    for (int i = 0; i < 600; i++) fifo_q.push_back(BPS'(i));
    s_mode = 2'b01; s_ir = 1;
    start = cyc;
    repeat (700) cycle();
    check("pace_reads", rd_log.size() >= 6, 1);
    if (rd_log.size() >= 6) begin
      check("pace_first", rd_log[0] - start, 101);
      for (int i = 0; i < 5; i++) check("pace_interval", rd_log[i+1] - rd_log[i], 100);
    end

    // Mode switch in PRESENT, then reset in PRESENT
    do_reset();
    for (int i = 0; i < 300; i++) fifo_q.push_back(24'hA00 + BPS'(i));
    s_mode = 2'b10; s_ir = 0; s_ur = 1;
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (i2s_valid) break;
    end
    s_mode = 2'b00;
    repeat (3) cycle();
    check("switch_hold_i2s", i2s_valid, 1);
    s_ir = 1;
    cycle();
    check("switch_final_i2s", i2s_valid, 1);
    check("switch_no_uart", uart_valid, 0);
    cycle();
    check("switch_idle", active, 0);
    cycle();
    check("switch_prefill", active, 1);
    s_ur = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (uart_valid) break;
    end
    check("switch_uart_present", uart_valid, 1);
    s_reset = 1;
    cycle();
    check("rst_mid_uart_valid", uart_valid, 0);
    check("rst_mid_active", active, 0);
    s_reset = 0; s_mode = 2'b11;
    cycle();
    check("rst_after_uart_valid", uart_valid, 0);
    check("rst_after_i2s_valid", i2s_valid, 0);
    check("rst_after_active", active, 0);
    check("rst_after_sample", uart_sample, 0);
    check("rst_after_underrun", underrun_cnt, 0);

    // Randomized traffic
    do_reset();
    push_pct = 40;
    for (int k = 0; k < 30000; k++) begin
      if ($urandom_range(199) == 0) begin
        s_mode = 2'($urandom_range(3));
        case ($urandom_range(2))
          0: push_pct = 10;
          1: push_pct = 40;
          default: push_pct = 80;
        endcase
      end
      s_ur = ($urandom_range(99) < 70);
      s_ir = ($urandom_range(99) < 70);
      s_push = ($urandom_range(99) < push_pct);
      s_push_val = BPS'($urandom);
      s_reset = ($urandom_range(2999) == 0);
      cycle();
    end
    s_reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
